// File: rtl/twowire_host_core_if.sv
// Request/response handshake and serial data pins of the two-wire host core.
// The master side is the command issuer (and the far end of the data pin),
// the slave side is the host core itself.
interface twowire_host_core_if;
    logic        req_vld;
    logic        req_rdy;
    logic [3:0]  req_cmd;
    logic [31:0] req_wdata;
    logic        resp_vld;
    logic [31:0] resp_rdata;
    logic        resp_perr;
    logic        dio_o;
    logic        dio_oe;
    logic        dio_i;

    modport master (
        output req_vld, req_cmd, req_wdata, dio_i,
        input  req_rdy, resp_vld, resp_rdata, resp_perr, dio_o, dio_oe
    );

    modport slave (
        input  req_vld, req_cmd, req_wdata, dio_i,
        output req_rdy, resp_vld, resp_rdata, resp_perr, dio_o, dio_oe
    );
endinterface

// File: rtl/twowire_host_core.sv
// Two-wire debug host core: serialises one command frame per accepted request
// (command, command parity, optional write payload + parity or turnaround,
// read payload + parity, turnaround) and reports completion with a one-cycle
// response pulse. Serial outputs are registered and decoded from next state.
module twowire_host_core #(
    parameter int ASIZE = 0,
    parameter int TURN  = 1
) (
    input  logic                dck,
    input  logic                drst_n,
    twowire_host_core_if.slave  bus
);
    localparam int         W_ADDR    = 8 * (1 + ASIZE);
    localparam logic [5:0] TURN_LOAD = 6'(TURN - 1);

    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_WR   = 2'd1;
    localparam logic [1:0] KIND_RD   = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CMD    = 4'd1,
        ST_CPAR   = 4'd2,
        ST_WDATA  = 4'd3,
        ST_WPAR   = 4'd4,
        ST_TURN_R = 4'd5,
        ST_RDATA  = 4'd6,
        ST_RPAR   = 4'd7,
        ST_TURN_W = 4'd8
    } state_t;

    // Payload length in bits for a command code; unknown codes carry no payload.
    function automatic logic [5:0] cmd_len(input logic [3:0] cmd);
        case (cmd)
            4'h1, 4'h2, 4'h7, 4'hB, 4'hD, 4'h6, 4'hC: cmd_len = 6'd32;
            4'h4:                                     cmd_len = 6'd4;
            4'h8, 4'h9, 4'hA:                         cmd_len = 6'(W_ADDR);
            default:                                  cmd_len = 6'd0;
        endcase
    endfunction

    // Frame shape for a command code; unknown codes become parity-only frames.
    function automatic logic [1:0] cmd_kind(input logic [3:0] cmd);
        case (cmd)
            4'h1, 4'h2, 4'h4, 4'h7, 4'h8, 4'hB, 4'hD: cmd_kind = KIND_RD;
            4'h6, 4'h9, 4'hA, 4'hC:                   cmd_kind = KIND_WR;
            default:                                  cmd_kind = KIND_NONE;
        endcase
    endfunction

    // Payload bit carried in the slot selected by the down-counter:
    // byte 0 first, MSB-first within each byte.
    function automatic logic [4:0] bit_index(input logic [5:0] len, input logic [5:0] cnt);
        logic [4:0] pos;
        pos       = 5'(len - 6'd1 - cnt);
        bit_index = {pos[4:3], ~pos[2:0]};
    endfunction

    // Even parity over the low len bits of a payload word.
    function automatic logic payload_parity(input logic [31:0] data, input logic [5:0] len);
        logic [31:0] mask;
        if (len >= 6'd32) begin
            mask = 32'hFFFF_FFFF;
        end else begin
            mask = (32'd1 << len) - 32'd1;
        end
        payload_parity = ^(data & mask);
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rx_q;
    logic        rxpar_q;
    logic        rpbit_q;
    logic        resp_vld_q;
    logic [31:0] resp_rdata_q;
    logic        resp_perr_q;
    logic        dio_o_q, dio_o_d;
    logic        dio_oe_q, dio_oe_d;
    logic        req_rdy_q, req_rdy_d;
    logic        accept_s;
    logic        frame_done_s;
    logic [5:0]  len_q_s;
    logic [5:0]  len_d_s;
    logic [1:0]  kind_q_s;

    assign accept_s = (state_q == ST_IDLE) && bus.req_vld;
    assign len_q_s  = cmd_len(cmd_q);
    assign kind_q_s = cmd_kind(cmd_q);
    assign len_d_s  = cmd_len(cmd_d);

    // FSM state and bit-sequencing counter register.
    always_ff @(posedge dck or negedge drst_n) begin
        if (!drst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter reload/decrement, request capture and frame-end detect.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_d        = cmd_q;
        wdata_d      = wdata_q;
        frame_done_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_CMD;
                    cnt_d   = 6'd3;
                    cmd_d   = bus.req_cmd;
                    wdata_d = bus.req_wdata;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 6'd0;
                end
            end
            ST_CMD: begin
                if (cnt_q == 6'd0) begin
                    state_d = ST_CPAR;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_CPAR: begin
                case (kind_q_s)
                    KIND_WR: begin
                        state_d = ST_WDATA;
                        cnt_d   = len_q_s - 6'd1;
                    end
                    KIND_RD: begin
                        state_d = ST_TURN_R;
                        cnt_d   = TURN_LOAD;
                    end
                    default: begin
                        state_d      = ST_IDLE;
                        cnt_d        = 6'd0;
                        frame_done_s = 1'b1;
                    end
                endcase
            end
            ST_WDATA: begin
                if (cnt_q == 6'd0) begin
                    state_d = ST_WPAR;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_WPAR: begin
                state_d      = ST_IDLE;
                cnt_d        = 6'd0;
                frame_done_s = 1'b1;
            end
            ST_TURN_R: begin
                if (cnt_q == 6'd0) begin
                    state_d = ST_RDATA;
                    cnt_d   = len_q_s - 6'd1;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_RDATA: begin
                if (cnt_q == 6'd0) begin
                    state_d = ST_RPAR;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_RPAR: begin
                state_d = ST_TURN_W;
                cnt_d   = TURN_LOAD;
            end
            ST_TURN_W: begin
                if (cnt_q == 6'd0) begin
                    state_d      = ST_IDLE;
                    frame_done_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // Pin and ready values for the state about to be entered, so the flops present them in that state.
    always_comb begin
        dio_o_d   = 1'b1;
        dio_oe_d  = 1'b1;
        req_rdy_d = 1'b0;
        case (state_d)
            ST_IDLE: begin
                req_rdy_d = 1'b1;
            end
            ST_CMD: begin
                dio_o_d = cmd_d[cnt_d[1:0]];
            end
            ST_CPAR: begin
                dio_o_d = ~^cmd_d;
            end
            ST_WDATA: begin
                dio_o_d = wdata_d[bit_index(len_d_s, cnt_d)];
            end
            ST_WPAR: begin
                dio_o_d = payload_parity(wdata_d, len_d_s);
            end
            ST_TURN_R, ST_RDATA, ST_RPAR, ST_TURN_W: begin
                dio_oe_d = 1'b0;
            end
            default: begin
                dio_o_d  = 1'b1;
                dio_oe_d = 1'b1;
            end
        endcase
    end

    // Registered serial pins and request-ready.
    always_ff @(posedge dck or negedge drst_n) begin
        if (!drst_n) begin
            dio_o_q   <= 1'b1;
            dio_oe_q  <= 1'b1;
            req_rdy_q <= 1'b1;
        end else begin
            dio_o_q   <= dio_o_d;
            dio_oe_q  <= dio_oe_d;
            req_rdy_q <= req_rdy_d;
        end
    end

    // Latched request plus the read shift register, its running parity and the received parity bit.
    always_ff @(posedge dck or negedge drst_n) begin
        if (!drst_n) begin
            cmd_q   <= 4'd0;
            wdata_q <= 32'd0;
            rx_q    <= 32'd0;
            rxpar_q <= 1'b0;
            rpbit_q <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            if (accept_s) begin
                rx_q    <= 32'd0;
                rxpar_q <= 1'b0;
                rpbit_q <= 1'b0;
            end else if (state_q == ST_RDATA) begin
                rx_q[bit_index(len_q_s, cnt_q)] <= bus.dio_i;
                rxpar_q                         <= rxpar_q ^ bus.dio_i;
            end else if (state_q == ST_RPAR) begin
                rpbit_q <= bus.dio_i;
            end else begin
                rpbit_q <= rpbit_q;
            end
        end
    end

    // Completion pulse; read data and parity error are held until the next completion.
    always_ff @(posedge dck or negedge drst_n) begin
        if (!drst_n) begin
            resp_vld_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_perr_q  <= 1'b0;
        end else if (frame_done_s) begin
            resp_vld_q <= 1'b1;
            if (kind_q_s == KIND_RD) begin
                // A 4-bit status read fills the top nibble of byte 0; return it right-justified.
                if (len_q_s == 6'd4) begin
                    resp_rdata_q <= {28'd0, rx_q[7:4]};
                end else begin
                    resp_rdata_q <= rx_q;
                end
                resp_perr_q <= rpbit_q ^ rxpar_q;
            end else begin
                resp_rdata_q <= 32'd0;
                resp_perr_q  <= 1'b0;
            end
        end else begin
            resp_vld_q <= 1'b0;
        end
    end

    assign bus.req_rdy    = req_rdy_q;
    assign bus.resp_vld   = resp_vld_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_perr  = resp_perr_q;
    assign bus.dio_o      = dio_o_q;
    assign bus.dio_oe     = dio_oe_q;
endmodule
